// File: rtl/twi_xfer_seq_pkg.sv
// twi_xfer_seq_pkg: shared TWI register map, bit positions, command codes and sequencer states.
package twi_xfer_seq_pkg;

    localparam logic [7:0] CTRLA_ADDR  = 8'hA0;
    localparam logic [7:0] CTRLC_ADDR  = 8'hA2;
    localparam logic [7:0] STATUS_ADDR = 8'hA3;
    localparam logic [7:0] BAUD_ADDR   = 8'hA4;
    localparam logic [7:0] DATA_ADDR   = 8'hA5;

    localparam int CTRLA_ENABLE_BIT  = 3;
    localparam int STATUS_RIF_BIT    = 7;
    localparam int STATUS_WIF_BIT    = 6;
    localparam int STATUS_RXACK_BIT  = 4;
    localparam int CTRLC_ACKACT_BIT  = 2;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_RESTART = 2'b01,
        CMD_RECEIVE = 2'b10,
        CMD_STOP    = 2'b11
    } twi_cmd_e;

    typedef enum logic [4:0] {
        S_IDLE,
        S_BAUD,
        S_ENA,
        S_SLAW,
        S_PW_SLAW,
        S_REG,
        S_PW_REG,
        S_WDAT,
        S_PW_WDAT,
        S_RSTRT,
        S_PC_RSTRT,
        S_SLAR,
        S_PW_SLAR,
        S_RECV,
        S_PR,
        S_RDAT,
        S_STOP,
        S_PC_STOP,
        S_DONE
    } xfer_state_e;

    function automatic logic is_poll(xfer_state_e s);
        return s inside {S_PW_SLAW, S_PW_REG, S_PW_WDAT, S_PC_RSTRT, S_PW_SLAR, S_PR, S_PC_STOP};
    endfunction

    function automatic logic [7:0] ctrlc_val(twi_cmd_e c, logic ackact);
        logic [7:0] v;
        v = '0;
        v[1:0] = c;
        v[CTRLC_ACKACT_BIT] = ackact;
        return v;
    endfunction

endpackage

// File: rtl/twi_xfer_seq_arb.sv
// twi_rr_arb: two-way round-robin arbiter; the requester that just won drops to lowest priority.
module twi_rr_arb
    import twi_xfer_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = (req_i == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_i;
        ptr_d = (en_i && |req_i) ? gnt_o[0] : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/twi_xfer_seq.sv
// twi_xfer_seq: arbitrates two register-job requesters and walks the TWI master register
// block through START/SLA/REG/[DATA | RESTART/SLA+R/RECEIVE]/STOP, polling STATUS and CTRLC.
module twi_xfer_seq
    import twi_xfer_seq_pkg::*;
#(
    parameter int          BUS_ADDR_DATA_LEN = 8,
    parameter logic [7:0]  BAUD_VAL          = 8'd24,
    parameter logic [11:0] POLL_TIMEOUT      = 12'd4095
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   req_i,
    input  logic [1:0]                   req_rnw_i,
    input  logic [13:0]                  req_sla_i,
    input  logic [15:0]                  req_reg_i,
    input  logic [15:0]                  req_wdata_i,
    output logic [1:0]                   done_o,
    output logic                         err_o,
    output logic [7:0]                   rdata_o,
    output logic [BUS_ADDR_DATA_LEN-1:0] twi_addr_o,
    output logic                         twi_wr_o,
    output logic                         twi_rd_o,
    output logic [7:0]                   twi_dat_o,
    input  logic [7:0]                   twi_dat_i
);

    xfer_state_e state_q, state_d, nxt;
    logic        gnt_q, gnt_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  sla_q, sla_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [11:0] tmo_q, tmo_d;
    logic [7:0]  addr_c;
    logic [1:0]  gnt;
    logic        met, nack, tmo_hit;

    twi_rr_arb u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_i),
        .en_i  (state_q == S_IDLE),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rnw_d     = rnw_q;
        sla_d     = sla_q;
        reg_d     = reg_q;
        wdat_d    = wdat_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        tmo_d     = is_poll(state_q) ? tmo_q + 12'd1 : '0;
        tmo_hit   = tmo_q == POLL_TIMEOUT - 12'd1;
        twi_wr_o  = 1'b0;
        twi_rd_o  = 1'b0;
        addr_c    = '0;
        twi_dat_o = '0;
        met       = 1'b0;
        nack      = 1'b0;
        nxt       = S_IDLE;
        case (state_q)
            S_IDLE: if (|req_i) begin
                gnt_d   = gnt[1];
                rnw_d   = gnt[1] ? req_rnw_i[1] : req_rnw_i[0];
                sla_d   = gnt[1] ? req_sla_i[13:7] : req_sla_i[6:0];
                reg_d   = gnt[1] ? req_reg_i[15:8] : req_reg_i[7:0];
                wdat_d  = gnt[1] ? req_wdata_i[15:8] : req_wdata_i[7:0];
                err_d   = 1'b0;
                state_d = S_BAUD;
            end
            S_BAUD: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, BAUD_ADDR, BAUD_VAL};
                state_d = S_ENA;
            end
            S_ENA: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, CTRLA_ADDR, 8'h1 << CTRLA_ENABLE_BIT};
                state_d = S_SLAW;
            end
            S_SLAW: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, DATA_ADDR, sla_q, 1'b0};
                state_d = S_PW_SLAW;
            end
            S_REG: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, DATA_ADDR, reg_q};
                state_d = S_PW_REG;
            end
            S_WDAT: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, DATA_ADDR, wdat_q};
                state_d = S_PW_WDAT;
            end
            S_RSTRT: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, CTRLC_ADDR, ctrlc_val(CMD_RESTART, 1'b0)};
                state_d = S_PC_RSTRT;
            end
            S_SLAR: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, DATA_ADDR, sla_q, 1'b1};
                state_d = S_PW_SLAR;
            end
            // single-byte read: NACK the byte so the slave releases SDA before STOP
            S_RECV: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, CTRLC_ADDR, ctrlc_val(CMD_RECEIVE, 1'b1)};
                state_d = S_PR;
            end
            S_RDAT: begin
                {twi_rd_o, addr_c} = {1'b1, DATA_ADDR};
                rdata_d = twi_dat_i;
                state_d = S_STOP;
            end
            S_STOP: begin
                {twi_wr_o, addr_c, twi_dat_o} = {1'b1, CTRLC_ADDR, ctrlc_val(CMD_STOP, 1'b0)};
                state_d = S_PC_STOP;
            end
            S_PW_SLAW, S_PW_REG, S_PW_WDAT, S_PW_SLAR: begin
                {twi_rd_o, addr_c} = {1'b1, STATUS_ADDR};
                met  = twi_dat_i[STATUS_WIF_BIT];
                nack = twi_dat_i[STATUS_RXACK_BIT];
                nxt  = state_q == S_PW_SLAW ? S_REG :
                       state_q == S_PW_REG  ? (rnw_q ? S_RSTRT : S_WDAT) :
                       state_q == S_PW_SLAR ? S_RECV : S_STOP;
            end
            S_PC_RSTRT, S_PC_STOP: begin
                {twi_rd_o, addr_c} = {1'b1, CTRLC_ADDR};
                met = twi_dat_i[1:0] == CMD_NOP;
                nxt = state_q == S_PC_RSTRT ? S_SLAR : S_DONE;
            end
            S_PR: begin
                {twi_rd_o, addr_c} = {1'b1, STATUS_ADDR};
                met = twi_dat_i[STATUS_RIF_BIT];
                nxt = S_RDAT;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // a stuck STOP goes straight to DONE rather than issuing another STOP
        if (is_poll(state_q)) begin
            if (met) begin
                state_d = nack ? S_STOP : nxt;
                err_d   = err_q | nack;
            end else if (tmo_hit) begin
                state_d = (state_q == S_PC_STOP) ? S_DONE : S_STOP;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            rnw_q   <= 1'b0;
            sla_q   <= '0;
            reg_q   <= '0;
            wdat_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rnw_q   <= rnw_d;
            sla_q   <= sla_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign twi_addr_o = BUS_ADDR_DATA_LEN'(addr_c);
    assign done_o     = (state_q == S_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign err_o      = (state_q == S_DONE) && err_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_twi_xfer_seq.sv
// tb_twi_xfer_seq: directed jobs against a behavioural TWI register-block model; expected bus
// writes and completions are queued at issue time and checked by an independent monitor.
module tb_twi_xfer_seq;

    typedef struct {
        logic [1:0] done;
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
    } exp_t;

    localparam logic [7:0] BAUD_V = 8'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  rnw = 2'b00;
    logic [6:0]  sla0 = '0, sla1 = '0;
    logic [7:0]  reg0 = '0, reg1 = '0, wd0 = '0, wd1 = '0;
    logic [1:0]  done_o;
    logic        err_o;
    logic [7:0]  rdata_o;
    logic [7:0]  twi_addr_o;
    logic        twi_wr_o, twi_rd_o;
    logic [7:0]  twi_dat_o, twi_dat;

    logic        wif, rif, rxack;
    logic [1:0]  cmd;
    int          wcnt, ccnt, rcnt;
    logic        stall = 1'b0, rstall = 1'b0;
    logic [7:0]  rbyte = 8'h00;
    logic [6:0]  absent = 7'h22;

    logic [15:0] wq[$];
    exp_t        dq[$];
    logic [15:0] ew;
    exp_t        ed;
    int          total = 0, bad = 0, st_reads = 0;

    always #5 clk = ~clk;

    twi_xfer_seq #(
        .BUS_ADDR_DATA_LEN (8),
        .BAUD_VAL          (BAUD_V),
        .POLL_TIMEOUT      (12'd15)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_rnw_i   (rnw),
        .req_sla_i   ({sla1, sla0}),
        .req_reg_i   ({reg1, reg0}),
        .req_wdata_i ({wd1, wd0}),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .twi_addr_o  (twi_addr_o),
        .twi_wr_o    (twi_wr_o),
        .twi_rd_o    (twi_rd_o),
        .twi_dat_o   (twi_dat_o),
        .twi_dat_i   (twi_dat)
    );

    // TWI register block: XMEGA-style STATUS {RIF,WIF,-,RXACK,...}, CTRLC CMD self-clears
    always_comb begin
        twi_dat = 8'h00;
        if (twi_addr_o == 8'hA3) twi_dat = {rif, wif, 1'b0, rxack, 4'b0000};
        else if (twi_addr_o == 8'hA2) twi_dat = {6'b0, cmd};
        else if (twi_addr_o == 8'hA5) twi_dat = rbyte;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wif <= 1'b0; rif <= 1'b0; rxack <= 1'b0; cmd <= 2'b00;
            wcnt <= 0; ccnt <= 0; rcnt <= 0;
        end else begin
            if (wcnt > 0) begin wcnt <= wcnt - 1; if (wcnt == 1 && !stall) wif <= 1'b1; end
            if (ccnt > 0) begin ccnt <= ccnt - 1; if (ccnt == 1) cmd <= 2'b00; end
            if (rcnt > 0) begin rcnt <= rcnt - 1; if (rcnt == 1 && !rstall) rif <= 1'b1; end
            if (twi_wr_o && twi_addr_o == 8'hA5) begin
                wif <= 1'b0; wcnt <= 3; rxack <= (twi_dat_o[7:1] == absent);
            end
            if (twi_wr_o && twi_addr_o == 8'hA2) begin
                wif <= 1'b0; cmd <= twi_dat_o[1:0]; ccnt <= 2;
                if (twi_dat_o[1:0] == 2'b10) rcnt <= 3;
            end
            if (twi_rd_o && twi_addr_o == 8'hA5) rif <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (twi_rd_o && twi_addr_o == 8'hA3) st_reads++;
            if (twi_wr_o && twi_rd_o) begin
                total++; bad++;
                $display("FAIL bus_excl: wr=1 rd=1 together, required at most one");
            end
            if (twi_wr_o) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL bus_wr: got %h<=%h, required no write", twi_addr_o, twi_dat_o);
                end else begin
                    ew = wq.pop_front();
                    if ({twi_addr_o, twi_dat_o} !== ew) begin
                        bad++;
                        $display("FAIL bus_wr: got %h<=%h, required %h<=%h", twi_addr_o, twi_dat_o, ew[15:8], ew[7:0]);
                    end
                end
            end
            if (done_o != 2'b00) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL done: got done=%b err=%b, required no completion", done_o, err_o);
                end else begin
                    ed = dq.pop_front();
                    if (done_o !== ed.done || err_o !== ed.err || (ed.chk_rd && rdata_o !== ed.rdata)) begin
                        bad++;
                        $display("FAIL done: got done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                                 done_o, err_o, rdata_o, ed.done, ed.err, ed.rdata);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // mode 0 normal, 1 NACK on address, 2 WIF never arrives, 3 aborted by reset during receive
    function automatic void push_job(int idx, bit r, logic [6:0] s, logic [7:0] g, logic [7:0] w,
                                     int mode, logic [7:0] rb);
        wq.push_back({8'hA4, BAUD_V});
        wq.push_back({8'hA0, 8'h08});
        wq.push_back({8'hA5, s, 1'b0});
        if (mode == 0 || mode == 3) begin
            wq.push_back({8'hA5, g});
            if (!r) wq.push_back({8'hA5, w});
            else begin
                wq.push_back({8'hA2, 8'h01});
                wq.push_back({8'hA5, s, 1'b1});
                wq.push_back({8'hA2, 8'h06});
            end
        end
        if (mode != 3) begin
            wq.push_back({8'hA2, 8'h03});
            dq.push_back('{done: (idx == 1) ? 2'b10 : 2'b01, err: mode != 0,
                           chk_rd: r && mode == 0, rdata: rb});
        end
    endfunction

    task automatic set_job(input int idx, input bit r, input logic [6:0] s, input logic [7:0] g,
                           input logic [7:0] w);
        if (idx == 0) begin sla0 = s; reg0 = g; wd0 = w; end
        else begin sla1 = s; reg1 = g; wd1 = w; end
        rnw[idx] = r;
        req[idx] = 1'b1;
    endtask

    task automatic run_req(input int idx, input bit r, input logic [6:0] s, input logic [7:0] g,
                           input logic [7:0] w);
        int n;
        n = 0;
        set_job(idx, r, s, g, w);
        do begin @(negedge clk); n++; end while (!done_o[idx] && n < 3000);
        if (!done_o[idx]) begin
            total++; bad++;
            $display("FAIL req%0d_wait: got no done_o in %0d cycles, required a done pulse", idx, n);
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_wr", twi_wr_o, 0);
        chk("rst_rd", twi_rd_o, 0);
        chk("rst_addr", twi_addr_o, 0);
        chk("rst_dat", twi_dat_o, 0);
        chk("rst_rdata", rdata_o, 0);
        rst = 1'b0;
        @(negedge clk);

        push_job(0, 0, 7'h3C, 8'h00, 8'hAF, 0, 8'h00);
        run_req(0, 0, 7'h3C, 8'h00, 8'hAF);

        rbyte = 8'h5A;
        push_job(1, 1, 7'h50, 8'h10, 8'h00, 0, 8'h5A);
        run_req(1, 1, 7'h50, 8'h10, 8'h00);
        chk("t2_rdata_hold", rdata_o, 8'h5A);

        push_job(1, 0, 7'h22, 8'h01, 8'h33, 1, 8'h00);
        run_req(1, 0, 7'h22, 8'h01, 8'h33);

        rbyte = 8'hC3;
        push_job(0, 0, 7'h3C, 8'h05, 8'h11, 0, 8'h00);
        push_job(1, 1, 7'h50, 8'h20, 8'h00, 0, 8'hC3);
        push_job(0, 1, 7'h50, 8'h21, 8'h00, 0, 8'hC3);
        push_job(1, 0, 7'h3C, 8'h06, 8'h22, 0, 8'h00);
        fork
            begin run_req(0, 0, 7'h3C, 8'h05, 8'h11); run_req(0, 1, 7'h50, 8'h21, 8'h00); end
            begin run_req(1, 1, 7'h50, 8'h20, 8'h00); run_req(1, 0, 7'h3C, 8'h06, 8'h22); end
        join

        stall = 1'b1;
        st_reads = 0;
        push_job(0, 0, 7'h3C, 8'h07, 8'h08, 2, 8'h00);
        run_req(0, 0, 7'h3C, 8'h07, 8'h08);
        stall = 1'b0;
        chk("t5_polls_ok", (st_reads >= 15 && st_reads <= 16) ? 1 : 0, 1);

        rstall = 1'b1;
        rbyte = 8'h77;
        push_job(0, 1, 7'h50, 8'h30, 8'h00, 3, 8'h00);
        set_job(0, 1, 7'h50, 8'h30, 8'h00);
        n = 0;
        while (wq.size() != 0 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("t6_in_poll_r", {twi_rd_o, twi_addr_o}, {1'b1, 8'hA3});
        rst = 1'b1;
        #1;
        chk("t6_rst_done", done_o, 0);
        chk("t6_rst_bus", {twi_wr_o, twi_rd_o, twi_addr_o, twi_dat_o}, 0);
        chk("t6_rst_rdata", rdata_o, 0);
        req[0] = 1'b0;
        rstall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_job(0, 0, 7'h3C, 8'h09, 8'h5A, 0, 8'h00);
        run_req(0, 0, 7'h3C, 8'h09, 8'h5A);

        repeat (5) @(negedge clk);
        chk("wq_drained", wq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
